// File: rtl/ex_mem_stage.sv
// Execute-to-memory pipeline register with branch resolution, overflow trap
// handling and the memory-stage forwarding source for the ALU bypass.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_v,
  input  logic              alu_zero,
  input  logic              ex_trap_ov,
  input  logic              ex_beq,
  input  logic              ex_bne,
  input  logic [PC_W-1:0]   ex_br_target,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              flush,
  input  logic              mem_ready,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_alu_res,
  output logic [DATA_W-1:0] mem_store_data,
  output logic [REG_AW-1:0] mem_rd,
  output logic              mem_reg_write,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              br_taken,
  output logic [PC_W-1:0]   br_target,
  output logic              ov_exc,
  output logic [PC_W-1:0]   epc,
  output logic [CNT_W-1:0]  ov_count,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              mem_valid_q, mem_valid_d;
  logic [DATA_W-1:0] alu_res_q, alu_res_d;
  logic [DATA_W-1:0] store_data_q, store_data_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              br_taken_q, br_taken_d;
  logic [PC_W-1:0]   br_target_q, br_target_d;
  logic              ov_exc_q, ov_exc_d;
  logic [PC_W-1:0]   epc_q, epc_d;
  logic [CNT_W-1:0]  ov_count_q, ov_count_d;
  logic              capture, trap;

  always_comb begin
    ex_ready = (state_q == RUN) && (!mem_valid_q || mem_ready);
    capture  = ex_valid && ex_ready && !flush;
    trap     = capture && ex_trap_ov && alu_v;

    state_d      = state_q;
    mem_valid_d  = mem_valid_q;
    alu_res_d    = alu_res_q;
    store_data_d = store_data_q;
    rd_d         = rd_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    br_target_d  = br_target_q;
    epc_d        = epc_q;
    ov_count_d   = ov_count_q;
    br_taken_d   = 1'b0;
    ov_exc_d     = trap;

    if (flush) begin
      mem_valid_d = 1'b0;
      state_d     = RUN;
    end else if (capture) begin
      alu_res_d    = alu_res;
      store_data_d = ex_store_data;
      rd_d         = ex_rd;
      if (trap) begin
        // Trapping entry is kept invisible: no valid, no side-effect controls.
        mem_valid_d = 1'b0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        epc_d       = ex_pc;
        state_d     = HALT;
        if (ov_count_q != '1) ov_count_d = ov_count_q + CNT_W'(1);
      end else begin
        mem_valid_d = 1'b1;
        reg_write_d = ex_reg_write;
        mem_read_d  = ex_mem_read;
        mem_write_d = ex_mem_write;
        br_taken_d  = (ex_beq && alu_zero) || (ex_bne && !alu_zero);
        br_target_d = ex_br_target;
      end
    end else if (mem_ready) begin
      mem_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      mem_valid_q  <= 1'b0;
      alu_res_q    <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      br_taken_q   <= 1'b0;
      br_target_q  <= '0;
      ov_exc_q     <= 1'b0;
      epc_q        <= '0;
      ov_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_valid_q  <= mem_valid_d;
      alu_res_q    <= alu_res_d;
      store_data_q <= store_data_d;
      rd_q         <= rd_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      br_taken_q   <= br_taken_d;
      br_target_q  <= br_target_d;
      ov_exc_q     <= ov_exc_d;
      epc_q        <= epc_d;
      ov_count_q   <= ov_count_d;
    end
  end

  assign mem_valid      = mem_valid_q;
  assign mem_alu_res    = alu_res_q;
  assign mem_store_data = store_data_q;
  assign mem_rd         = rd_q;
  assign mem_reg_write  = reg_write_q;
  assign mem_mem_read   = mem_read_q;
  assign mem_mem_write  = mem_write_q;
  assign br_taken       = br_taken_q;
  assign br_target      = br_target_q;
  assign ov_exc         = ov_exc_q;
  assign epc            = epc_q;
  assign ov_count       = ov_count_q;
  assign fwd_valid      = mem_valid_q && reg_write_q && (rd_q != '0);
  assign fwd_rd         = rd_q;
  assign fwd_data       = alu_res_q;

endmodule
